// File: rtl/trace_width_ctrl.sv
// Trace capture bus-width controller: hunts for the width that produces sync
// detections, confirms it within one dwell window, then supervises the lock.
//
// state   | meaning
// MANUAL  | width follows manualWidth, dwell/loss timers idle
// HUNT    | dwell at each candidate width, advance 3 -> 2 -> 1 -> 3 on expiry
// CONFIRM | counting syncs at the candidate width within one dwell window
// LOCKED  | width fixed; syncs or frames keep the loss timer from expiring
module trace_width_ctrl #(
    parameter int unsigned DWELL        = 65536,
    parameter int unsigned LOCK_SYNCS   = 2,
    parameter int unsigned LOSS_TIMEOUT = 1048576,
    parameter int unsigned SETTLE       = 18
) (
    input  logic        traceClkin,
    input  logic        rst,
    input  logic        autoEn,
    input  logic [1:0]  manualWidth,
    input  logic        syncPulse,
    input  logic        FrAvail,
    output logic [1:0]  width,
    output logic        locked,
    output logic [1:0]  state,
    output logic [7:0]  huntCount,
    output logic [15:0] frameCount
);
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned LW = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL - 1);
    localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [3:0]    SYNC_GOAL   = 4'(LOCK_SYNCS);

    typedef enum logic [1:0] {
        ST_MANUAL  = 2'd0,
        ST_HUNT    = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      width_q, width_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [LW-1:0]   loss_q, loss_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [3:0]      sync_cnt_q, sync_cnt_d;
    logic [7:0]      hunt_cnt_q, hunt_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            fr_q;

    logic            sync_ok, frame_ev, dwell_exp, loss_exp, lock_hit, load_settle;
    logic [3:0]      sync_cnt_inc;

    function automatic logic [1:0] next_width(input logic [1:0] w);
        case (w)
            2'd3:    return 2'd2;
            2'd2:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    assign sync_ok      = syncPulse && (settle_q == '0);
    assign frame_ev     = FrAvail ^ fr_q;
    assign dwell_exp    = (dwell_q == DWELL_LAST);
    assign loss_exp     = (loss_q == LOSS_LAST);
    assign sync_cnt_inc = sync_cnt_q + 4'd1;
    assign lock_hit     = (sync_cnt_inc >= SYNC_GOAL);

    always_ff @(posedge traceClkin or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            width_q     <= 2'd3;
            dwell_q     <= '0;
            loss_q      <= '0;
            settle_q    <= SETTLE_LOAD;
            sync_cnt_q  <= '0;
            hunt_cnt_q  <= '0;
            frame_cnt_q <= '0;
            fr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            dwell_q     <= dwell_d;
            loss_q      <= loss_d;
            settle_q    <= settle_d;
            sync_cnt_q  <= sync_cnt_d;
            hunt_cnt_q  <= hunt_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            fr_q        <= FrAvail;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!autoEn) begin
            state_d = ST_MANUAL;
        end else begin
            case (state_q)
                ST_MANUAL:  state_d = ST_HUNT;
                ST_HUNT:    if (sync_ok) state_d = (LOCK_SYNCS <= 1) ? ST_LOCKED : ST_CONFIRM;
                ST_CONFIRM: begin
                    if (sync_ok) begin
                        if (lock_hit) state_d = ST_LOCKED;
                    end else if (dwell_exp) begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED:  if (!sync_ok && !frame_ev && loss_exp) state_d = ST_HUNT;
                default:    state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        width_d     = width_q;
        dwell_d     = dwell_q;
        loss_d      = loss_q;
        sync_cnt_d  = sync_cnt_q;
        hunt_cnt_d  = hunt_cnt_q;
        frame_cnt_d = frame_cnt_q;
        load_settle = 1'b0;
        if (!autoEn) begin
            width_d    = manualWidth;
            dwell_d    = '0;
            loss_d     = '0;
            sync_cnt_d = '0;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    width_d     = 2'd3;
                    dwell_d     = '0;
                    load_settle = 1'b1;
                end
                ST_HUNT: begin
                    if (sync_ok) begin
                        dwell_d    = '0;
                        loss_d     = '0;
                        sync_cnt_d = 4'd1;
                    end else if (dwell_exp) begin
                        width_d     = next_width(width_q);
                        dwell_d     = '0;
                        hunt_cnt_d  = (hunt_cnt_q == 8'hFF) ? hunt_cnt_q : hunt_cnt_q + 8'd1;
                        load_settle = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (sync_ok) begin
                        sync_cnt_d = sync_cnt_inc;
                        loss_d     = '0;
                        dwell_d    = dwell_exp ? '0 : dwell_q + 1'b1;
                    end else if (dwell_exp) begin
                        width_d     = next_width(width_q);
                        dwell_d     = '0;
                        sync_cnt_d  = '0;
                        hunt_cnt_d  = (hunt_cnt_q == 8'hFF) ? hunt_cnt_q : hunt_cnt_q + 8'd1;
                        load_settle = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (sync_ok || frame_ev) begin
                        loss_d = '0;
                        if (frame_ev) frame_cnt_d = frame_cnt_q + 16'd1;
                    end else if (loss_exp) begin
                        // retry the width we were locked at before hunting onward
                        loss_d      = '0;
                        dwell_d     = '0;
                        sync_cnt_d  = '0;
                        load_settle = 1'b1;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        settle_d = (load_settle || (width_d != width_q)) ? SETTLE_LOAD
                 : (settle_q != '0) ? settle_q - 1'b1 : settle_q;
    end

    always_comb begin
        locked     = (state_q == ST_LOCKED);
        width      = width_q;
        state      = state_q;
        huntCount  = hunt_cnt_q;
        frameCount = frame_cnt_q;
    end
endmodule

// File: tb/tb_trace_width_ctrl.sv
// Directed bench for trace_width_ctrl: expectations are queued as stimulus is
// applied and drained against a long-dwell and a short-dwell instance.
module tb_trace_width_ctrl;
    logic        traceClkin = 1'b0;
    logic        rst;
    logic        autoEn;
    logic [1:0]  manualWidth;
    logic        syncPulse;
    logic        FrAvail;

    logic [1:0]  width_m, state_m, width_f, state_f;
    logic        locked_m, locked_f;
    logic [7:0]  hunt_m, hunt_f;
    logic [15:0] frame_m, frame_f;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          which;
        logic [1:0]  st;
        logic [1:0]  w;
        logic        lk;
        logic [7:0]  hc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];

    always #5 traceClkin = ~traceClkin;

    trace_width_ctrl #(.DWELL(64), .LOCK_SYNCS(2), .LOSS_TIMEOUT(256), .SETTLE(18)) dut_m (
        .traceClkin(traceClkin), .rst(rst), .autoEn(autoEn), .manualWidth(manualWidth),
        .syncPulse(syncPulse), .FrAvail(FrAvail), .width(width_m), .locked(locked_m),
        .state(state_m), .huntCount(hunt_m), .frameCount(frame_m));

    trace_width_ctrl #(.DWELL(8), .LOCK_SYNCS(2), .LOSS_TIMEOUT(256), .SETTLE(18)) dut_f (
        .traceClkin(traceClkin), .rst(rst), .autoEn(autoEn), .manualWidth(manualWidth),
        .syncPulse(syncPulse), .FrAvail(FrAvail), .width(width_f), .locked(locked_f),
        .state(state_f), .huntCount(hunt_f), .frameCount(frame_f));

    task automatic tick(input int n);
        repeat (n) @(posedge traceClkin);
        #1;
    endtask

    task automatic push(input string tag, input int which, input logic [1:0] st,
                        input logic [1:0] w, input logic lk, input logic [7:0] hc,
                        input logic [15:0] fc);
        exp_t e;
        e = '{tag: tag, which: which, st: st, w: w, lk: lk, hc: hc, fc: fc};
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s.%s observed %0d expected %0d", tag, fld, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.which == 0) begin
                cmp(e.tag, "state", 32'(state_m), 32'(e.st));
                cmp(e.tag, "width", 32'(width_m), 32'(e.w));
                cmp(e.tag, "locked", 32'(locked_m), 32'(e.lk));
                cmp(e.tag, "huntCount", 32'(hunt_m), 32'(e.hc));
                cmp(e.tag, "frameCount", 32'(frame_m), 32'(e.fc));
            end else begin
                cmp(e.tag, "state", 32'(state_f), 32'(e.st));
                cmp(e.tag, "width", 32'(width_f), 32'(e.w));
                cmp(e.tag, "locked", 32'(locked_f), 32'(e.lk));
                cmp(e.tag, "huntCount", 32'(hunt_f), 32'(e.hc));
                cmp(e.tag, "frameCount", 32'(frame_f), 32'(e.fc));
            end
        end
    endtask

    task automatic pulse_sync();
        syncPulse = 1'b1;
        tick(1);
        syncPulse = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired n_tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; autoEn = 1'b1; manualWidth = 2'd0; syncPulse = 1'b0; FrAvail = 1'b0;
        #3;
        push("reset_m", 0, 2'd1, 2'd3, 1'b0, 8'd0, 16'd0);
        push("reset_f", 1, 2'd1, 2'd3, 1'b0, 8'd0, 16'd0);
        drain();
        tick(1);
        rst = 1'b0;

        tick(63);
        push("dwell_last_w3", 0, 2'd1, 2'd3, 1'b0, 8'd0, 16'd0);
        drain();
        tick(1);
        push("advance_w2", 0, 2'd1, 2'd2, 1'b0, 8'd1, 16'd0);
        drain();

        tick(5);
        pulse_sync();
        push("settle_ignore", 0, 2'd1, 2'd2, 1'b0, 8'd1, 16'd0);
        drain();

        tick(15);
        pulse_sync();
        push("confirm", 0, 2'd2, 2'd2, 1'b0, 8'd1, 16'd0);
        drain();
        tick(3);
        pulse_sync();
        push("lock", 0, 2'd3, 2'd2, 1'b1, 8'd1, 16'd0);
        drain();

        for (int i = 0; i < 65535; i++) begin
            FrAvail = ~FrAvail;
            tick(1);
        end
        push("frames_65535", 0, 2'd3, 2'd2, 1'b1, 8'd1, 16'd65535);
        drain();
        for (int i = 0; i < 2; i++) begin
            FrAvail = ~FrAvail;
            tick(1);
        end
        push("frames_wrap", 0, 2'd3, 2'd2, 1'b1, 8'd1, 16'd1);
        drain();

        tick(255);
        push("loss_last", 0, 2'd3, 2'd2, 1'b1, 8'd1, 16'd1);
        drain();
        tick(1);
        push("loss_expire", 0, 2'd1, 2'd2, 1'b0, 8'd1, 16'd1);
        drain();

        tick(18);
        pulse_sync();
        push("reconfirm", 0, 2'd2, 2'd2, 1'b0, 8'd1, 16'd1);
        drain();
        autoEn = 1'b0; manualWidth = 2'd1;
        tick(1);
        push("manual_w1", 0, 2'd0, 2'd1, 1'b0, 8'd1, 16'd1);
        drain();
        manualWidth = 2'd2;
        tick(1);
        push("manual_w2", 0, 2'd0, 2'd2, 1'b0, 8'd1, 16'd1);
        drain();
        autoEn = 1'b1;
        tick(1);
        push("auto_rehunt", 0, 2'd1, 2'd3, 1'b0, 8'd1, 16'd1);
        drain();

        tick(10);
        rst = 1'b1;
        #1;
        push("midhunt_reset", 0, 2'd1, 2'd3, 1'b0, 8'd0, 16'd0);
        drain();
        autoEn = 1'b0; manualWidth = 2'd2;
        tick(2);
        push("held_reset", 0, 2'd1, 2'd3, 1'b0, 8'd0, 16'd0);
        drain();
        rst = 1'b0;
        tick(1);
        push("release_manual", 0, 2'd0, 2'd2, 1'b0, 8'd0, 16'd0);
        drain();

        rst = 1'b1; autoEn = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(8);
        push("cyc_w2", 1, 2'd1, 2'd2, 1'b0, 8'd1, 16'd0);
        drain();
        tick(8);
        push("cyc_w1", 1, 2'd1, 2'd1, 1'b0, 8'd2, 16'd0);
        drain();
        tick(8);
        push("cyc_w3", 1, 2'd1, 2'd3, 1'b0, 8'd3, 16'd0);
        drain();
        tick(8 * 251);
        push("hunt_254", 1, 2'd1, 2'd1, 1'b0, 8'd254, 16'd0);
        drain();
        tick(8);
        push("hunt_255", 1, 2'd1, 2'd3, 1'b0, 8'd255, 16'd0);
        drain();
        tick(8 * 45);
        push("hunt_sat", 1, 2'd1, 2'd3, 1'b0, 8'd255, 16'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trace_width_ctrl.md
TRACE_WIDTH_CTRL -- requirements
Module: trace_width_ctrl

Interface
REQ-001 Parameter DWELL, 65536, clocks spent at each candidate width while hunting or confirming.
REQ-002 Parameter LOCK_SYNCS, 2, sync pulses required within one dwell window to declare lock (range 1..15).
REQ-003 Parameter LOSS_TIMEOUT, 1048576, clocks without a sync pulse or a frame before lock is declared lost.
REQ-004 Parameter SETTLE, 18, clocks after any width change during which syncPulse is ignored.
REQ-005 traceClkin  in  1  clock shared with the trace capture datapath.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 autoEn  in  1  1 = automatic width hunt; 0 = manual width.
REQ-008 manualWidth  in  2  width code used when autoEn=0.
REQ-009 syncPulse  in  1  one-clock pulse from capture datapath on each full-sync detection.
REQ-010 FrAvail  in  1  frame-ready toggle from capture datapath.
REQ-011 width  out  2  registered bus-width code to capture datapath (3 = 4 bits, 2 = 2 bits, 1 = 1 bit).
REQ-012 locked  out  1  high only in state LOCKED.
REQ-013 state  out  2  current state: 0 MANUAL, 1 HUNT, 2 CONFIRM, 3 LOCKED.
REQ-014 huntCount  out  8  count of width advances since reset; saturates at 255.
REQ-015 frameCount  out  16  frames seen while LOCKED; wraps 65535 -> 0.

Function
REQ-016 All state, counters and outputs SHALL update only on the rising edge of traceClkin.
REQ-017 Frame event = FrAvail XOR its previous-clock registered copy; one event per toggle.
REQ-018 Settle blanking: a settle counter loads SETTLE-1 on every width change and decrements to 0; syncPulse is ignored while it is nonzero.
REQ-019 Priority per clock: autoEn=0, then accepted syncPulse, then frame event, then timer expiry.
REQ-020 MANUAL: width <= manualWidth every clock; locked=0; dwell and loss timers held at 0; on autoEn=1 -> HUNT, width <= 3, dwell counter 0, settle counter loaded.
REQ-021 Any state with autoEn=0 -> MANUAL next clock; syncCnt cleared.
REQ-022 HUNT: dwell counter increments; accepted syncPulse -> CONFIRM, syncCnt <= 1, dwell counter <= 0; if LOCK_SYNCS=1, go directly to LOCKED instead.
REQ-023 HUNT, dwell counter = DWELL-1 and no accepted syncPulse: width advances 3 -> 2 -> 1 -> 3; dwell counter <= 0; huntCount increments (saturating); settle counter loaded.
REQ-024 CONFIRM: accepted syncPulse increments syncCnt; reaching LOCK_SYNCS -> LOCKED, loss counter <= 0.
REQ-025 CONFIRM, dwell expiry before LOCK_SYNCS syncs: -> HUNT with width advanced per REQ-023, syncCnt <= 0.
REQ-026 LOCKED: accepted syncPulse or frame event clears loss counter; otherwise it increments; frame event increments frameCount.
REQ-027 LOCKED, loss counter = LOSS_TIMEOUT-1: -> HUNT with width unchanged (current width retried first), dwell counter <= 0, settle counter loaded, huntCount unchanged.
REQ-028 Width code 0 SHALL never be driven outside MANUAL.
REQ-029 Timer widths: dwell counter ceil(log2(DWELL)) bits; loss counter ceil(log2(LOSS_TIMEOUT)) bits; no overflow before the compare value.

Reset
REQ-030 rst SHALL asynchronously force state=HUNT, width=3, locked=0, huntCount=0, frameCount=0, syncCnt=0, all timers 0, settle counter SETTLE-1, FrAvail shadow 0.
REQ-031 With autoEn=0 at reset release, state SHALL be MANUAL one clock later.
REQ-032 rst asserted mid-hunt or mid-lock SHALL abandon all progress; no partial counts survive.

Verification
REQ-033 autoEn=1, DWELL=64, syncPulse at width=2 only -> width 3 for 64 clocks, then 2, CONFIRM, LOCKED after 2nd pulse; huntCount=1.
REQ-034 syncPulse 5 clocks after a width change (SETTLE=18) -> ignored; state stays HUNT.
REQ-035 LOCKED, no syncs or frames for LOSS_TIMEOUT clocks -> HUNT, width unchanged, locked=0 next clock.
REQ-036 LOCKED, 65537 FrAvail toggles -> frameCount=1; loss counter never expires.
REQ-037 autoEn 1 -> 0 during CONFIRM with manualWidth=1 -> MANUAL, width=1, locked=0 next clock; autoEn 0 -> 1 -> HUNT, width=3.
REQ-038 No syncPulse for 300 dwell windows -> width cycles 3, 2, 1, 3...; huntCount saturates at 255.
